fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 157 +++++++++++++++
 tb/tb_fetch_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue sitting between an address generator, a
// single-cycle-latency instruction memory and the decode stage.
//
// Addresses offered on the fetch side are forwarded straight to memory as a
// read. One cycle later the returned word is stored together with its address
// in a small circular buffer. Decode pulls entries from the head with a
// valid/ready handshake. A flush discards everything queued and the read that
// is still in flight.
//
// Ports
//   clk                 in   clock, all state updates on the rising edge
//   reset               in   synchronous, active-high reset
//   i_fetch_addr        in   AW  address offered by the address generator
//   i_fetch_addr_valid  in   1   i_fetch_addr is valid this cycle
//   o_fetch_ready       out  1   address accepted this cycle
//   i_flush             in   1   redirect: drop queued and in-flight entries
//   o_mem_en            out  1   memory read strobe
//   o_mem_addr          out  AW  memory read address
//   i_mem_rdata         in   IW  read data, one cycle after o_mem_en
//   o_instr_valid       out  1   head entry valid toward decode
//   i_instr_ready       in   1   decode accepts head entry
//   o_instr_out         out  IW  head instruction word
//   o_instr_pc          out  AW  head instruction address
//   o_occupancy         out  3   number of stored entries
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned AW    = 8,
    parameter int unsigned IW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_fetch_addr,
    input  logic          i_fetch_addr_valid,
    output logic          o_fetch_ready,
    input  logic          i_flush,
    output logic          o_mem_en,
    output logic [AW-1:0] o_mem_addr,
    input  logic [IW-1:0] i_mem_rdata,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    output logic [IW-1:0] o_instr_out,
    output logic [AW-1:0] o_instr_pc,
    output logic [2:0]    o_occupancy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // State
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic [AW-1:0] r_pend_pc;

    // Storage, no reset needed: r_count gates every read
    logic [AW-1:0] r_pc_mem   [DEPTH];
    logic [IW-1:0] r_data_mem [DEPTH];

    // Handshake qualifiers
    logic [CW:0]   w_credit;
    logic          w_fetch_ready;
    logic          w_issue;
    logic          w_enq;
    logic          w_instr_valid;
    logic          w_deq;

    // Next-state
    logic [PW-1:0] w_wr_ptr_next;
    logic [PW-1:0] w_rd_ptr_next;
    logic [CW-1:0] w_count_next;
    logic          w_inflight_next;
    logic [AW-1:0] w_pend_pc_next;

    // The in-flight read already owns a slot, so it counts against capacity.
    // A dequeue in the same cycle does not free a slot early.
    always_comb begin
        w_credit      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
        w_fetch_ready = !reset && !i_flush && (w_credit < (CW + 1)'(DEPTH));
        w_issue       = i_fetch_addr_valid && w_fetch_ready;
        w_enq         = r_inflight && !i_flush && !reset;
        w_instr_valid = (r_count != '0) && !i_flush && !reset;
        w_deq         = w_instr_valid && i_instr_ready;
    end

    always_comb begin
        w_wr_ptr_next   = r_wr_ptr;
        w_rd_ptr_next   = r_rd_ptr;
        w_count_next    = r_count;
        w_inflight_next = w_issue;
        w_pend_pc_next  = r_pend_pc;

        if (w_issue) begin
            w_pend_pc_next = i_fetch_addr;
        end
        // Pointers wrap naturally because DEPTH is a power of two
        if (w_enq) begin
            w_wr_ptr_next = r_wr_ptr + PW'(1);
        end
        if (w_deq) begin
            w_rd_ptr_next = r_rd_ptr + PW'(1);
        end

        unique case ({w_enq, w_deq})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase

        if (i_flush) begin
            w_wr_ptr_next   = '0;
            w_rd_ptr_next   = '0;
            w_count_next    = '0;
            w_inflight_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_pend_pc  <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_inflight <= w_inflight_next;
            r_pend_pc  <= w_pend_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc_mem[r_wr_ptr]   <= r_pend_pc;
            r_data_mem[r_wr_ptr] <= i_mem_rdata;
        end
    end

    // Outputs are forced low during reset because r_count still holds its
    // pre-reset value in that cycle.
    always_comb begin
        o_fetch_ready = w_fetch_ready;
        o_mem_en      = w_issue;
        o_mem_addr    = i_fetch_addr;
        o_instr_valid = w_instr_valid;
        o_instr_out   = reset ? '0 : r_data_mem[r_rd_ptr];
        o_instr_pc    = reset ? '0 : r_pc_mem[r_rd_ptr];
        o_occupancy   = reset ? 3'd0 : 3'(r_count);
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue. Inputs change 1 time unit after the rising
// edge; outputs are checked on the falling edge. A memory model returns
// addr + 0x1000 one cycle after each read strobe. Every decode handshake is
// checked against a queue of expected PCs pushed by the test sequence.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  fetch_addr;
    logic        fetch_addr_valid;
    logic        fetch_ready;
    logic        flush;
    logic        mem_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic [2:0]  occupancy;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_q[$];

    fetch_queue #(
        .AW    (8),
        .IW    (16),
        .DEPTH (4)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .i_fetch_addr       (fetch_addr),
        .i_fetch_addr_valid (fetch_addr_valid),
        .o_fetch_ready      (fetch_ready),
        .i_flush            (flush),
        .o_mem_en           (mem_en),
        .o_mem_addr         (mem_addr),
        .i_mem_rdata        (mem_rdata),
        .o_instr_valid      (instr_valid),
        .i_instr_ready      (instr_ready),
        .o_instr_out        (instr_out),
        .o_instr_pc         (instr_pc),
        .o_occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            mem_rdata <= 16'h1000 + {8'h00, mem_addr};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Decode-side monitor
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_instr", 32'(instr_pc), 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("out_pc", 32'(instr_pc), 32'(e));
                check("out_data", 32'(instr_out), 32'h1000 + 32'(e));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [7:0] a, input logic rdy, input logic fl);
        fetch_addr_valid = v;
        fetch_addr       = a;
        instr_ready      = rdy;
        flush            = fl;
    endtask

    task automatic drain(input int n);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) next_cycle();
        @(negedge clk);
        check("drain_occ", 32'(occupancy), 32'd0);
        check("drain_q_empty", 32'(exp_q.size()), 32'd0);
        next_cycle();
    endtask

    // Backpressure fill: four addresses offered with decode stalled
    task automatic fill4(input logic [7:0] base);
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, base + 8'(k), 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    int         m_count;
    int         m_inf;
    logic [7:0] na;
    logic       rdy;
    logic       exp_fr;
    logic       exp_iv;

    initial begin
        // ---------------- reset ----------------
        reset = 1'b1;
        set_in(1'b1, 8'h33, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
            check("rst_mem_en", 32'(mem_en), 32'd0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_occ", 32'(occupancy), 32'd0);
            next_cycle();
        end
        reset = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("idle_occ", 32'(occupancy), 32'd0);
        check("idle_fetch_ready", 32'(fetch_ready), 32'd1);
        next_cycle();

        // ---------------- streaming ----------------
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, 8'(k), 1'b1, 1'b0);
            exp_q.push_back(8'(k));
            @(negedge clk);
            check("strm_fetch_ready", 32'(fetch_ready), 32'd1);
            check("strm_mem_en", 32'(mem_en), 32'd1);
            check("strm_mem_addr", 32'(mem_addr), 32'(k));
            check("strm_valid", 32'(instr_valid), (k >= 2) ? 32'd1 : 32'd0);
            check("strm_occ", 32'(occupancy), (k >= 2) ? 32'd1 : 32'd0);
            next_cycle();
        end
        drain(3);

        // ---------------- backpressure ----------------
        for (int k = 0; k < 6; k++) begin
            set_in(1'b1, (k < 4) ? 8'h10 + 8'(k) : 8'h14, 1'b0, 1'b0);
            @(negedge clk);
            check("bp_fetch_ready", 32'(fetch_ready), (k < 4) ? 32'd1 : 32'd0);
            if (k >= 4) begin
                check("bp_valid", 32'(instr_valid), 32'd1);
                check("bp_hold_pc", 32'(instr_pc), 32'h10);
                check("bp_hold_data", 32'(instr_out), 32'h1010);
            end
            if (k == 5) check("bp_occ_full", 32'(occupancy), 32'd4);
            next_cycle();
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h10 + 8'(k));
        set_in(1'b1, 8'h14, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_no_credit", 32'(fetch_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        check("bp_credit_back", 32'(fetch_ready), 32'd1);
        exp_q.push_back(8'h14);
        next_cycle();
        drain(6);

        // ---------------- flush with in-flight ----------------
        fill4(8'h20);
        set_in(1'b1, 8'h30, 1'b1, 1'b1);
        @(negedge clk);
        check("fl_valid", 32'(instr_valid), 32'd0);
        check("fl_fetch_ready", 32'(fetch_ready), 32'd0);
        check("fl_mem_en", 32'(mem_en), 32'd0);
        next_cycle();
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_occ", 32'(occupancy), 32'd0);
        check("fl_valid_after", 32'(instr_valid), 32'd0);
        next_cycle();
        set_in(1'b1, 8'h40, 1'b1, 1'b0);
        exp_q.push_back(8'h40);
        @(negedge clk);
        check("fl_refetch_ready", 32'(fetch_ready), 32'd1);
        next_cycle();
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_lat1_valid", 32'(instr_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("fl_lat2_valid", 32'(instr_valid), 32'd1);
        check("fl_lat2_pc", 32'(instr_pc), 32'h40);
        next_cycle();
        drain(1);

        // ---------------- wrap with random decode stalls ----------------
        m_count = 0;
        m_inf   = 0;
        na      = 8'h50;
        for (int k = 0; k < 28; k++) begin
            rdy = (k < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            set_in(k < 20, na, rdy, 1'b0);
            @(negedge clk);
            exp_fr = (m_count + m_inf) < 4;
            exp_iv = (m_count != 0);
            check("wr_fetch_ready", 32'(fetch_ready), 32'(exp_fr));
            check("wr_valid", 32'(instr_valid), 32'(exp_iv));
            check("wr_occ", 32'(occupancy), 32'(m_count));
            m_count = m_count + m_inf - ((exp_iv && rdy) ? 1 : 0);
            if (k < 20 && exp_fr) begin
                m_inf = 1;
                exp_q.push_back(na);
                na = na + 8'h01;
            end else begin
                m_inf = 0;
            end
            next_cycle();
        end
        drain(1);

        // ---------------- reset mid-stream ----------------
        fill4(8'h60);
        reset = 1'b1;
        set_in(1'b1, 8'h70, 1'b1, 1'b0);
        @(negedge clk);
        check("mr_fetch_ready", 32'(fetch_ready), 32'd0);
        check("mr_mem_en", 32'(mem_en), 32'd0);
        check("mr_valid", 32'(instr_valid), 32'd0);
        check("mr_occ", 32'(occupancy), 32'd0);
        next_cycle();
        reset = 1'b0;
        set_in(1'b1, 8'h05, 1'b1, 1'b0);
        exp_q.push_back(8'h05);
        @(negedge clk);
        check("mr_post_ready", 32'(fetch_ready), 32'd1);
        check("mr_post_occ", 32'(occupancy), 32'd0);
        check("mr_post_valid", 32'(instr_valid), 32'd0);
        next_cycle();
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("mr_lat1_valid", 32'(instr_valid), 32'd0);
        next_cycle();
        @(negedge clk);
        check("mr_lat2_valid", 32'(instr_valid), 32'd1);
        check("mr_lat2_pc", 32'(instr_pc), 32'h05);
        next_cycle();
        drain(1);

        // ---------------- simultaneous enqueue and dequeue ----------------
        fill4(8'h80);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h80 + 8'(k));
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check("sim_occ_before", 32'(occupancy), 32'd3);
        check("sim_valid", 32'(instr_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        check("sim_occ_after", 32'(occupancy), 32'd3);
        next_cycle();
        drain(4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Safety net against a hung sequence
    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
